// File: rtl/serial_add_scheduler.sv
// ============================================================================
// serial_add_scheduler : round-robin shared bit-serial adder (LSB first)
// Revision 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module serial_add_scheduler #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0,
  input  logic [WIDTH-1:0] a0,
  input  logic [WIDTH-1:0] b0,
  input  logic             req1,
  input  logic [WIDTH-1:0] a1,
  input  logic [WIDTH-1:0] b1,
  output logic             gnt0,
  output logic             gnt1,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_sa;
  logic [WIDTH-1:0] r_sb;
  logic [WIDTH-1:0] r_res;
  logic             r_carry;
  logic [CW-1:0]    r_cnt;
  logic             r_ptr;

  logic w_hs1, w_hc1, w_bit, w_hc2, w_cnext, w_pick1;

  // Two half-adder cells; the OR of their carries forms the full-adder carry.
  assign w_hs1   = r_sa[0] ^ r_sb[0];
  assign w_hc1   = r_sa[0] & r_sb[0];
  assign w_bit   = w_hs1 ^ r_carry;
  assign w_hc2   = w_hs1 & r_carry;
  assign w_cnext = w_hc1 | w_hc2;

  assign w_pick1 = req1 & (~req0 | r_ptr);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_sa    <= '0;
      r_sb    <= '0;
      r_res   <= '0;
      r_carry <= 1'b0;
      r_cnt   <= '0;
      r_ptr   <= 1'b0;
      gnt0    <= 1'b0;
      gnt1    <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      sum     <= '0;
      cout    <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          done <= 1'b0;
          if (req0 | req1) begin
            gnt0    <= ~w_pick1;
            gnt1    <= w_pick1;
            r_sa    <= w_pick1 ? a1 : a0;
            r_sb    <= w_pick1 ? b1 : b0;
            r_carry <= 1'b0;
            r_cnt   <= '0;
            busy    <= 1'b1;
            r_state <= RUN;
          end
        end
        RUN: begin
          // After WIDTH shifts the result register is complete; publish it.
          if (r_cnt == CW'(WIDTH)) begin
            sum     <= r_res;
            cout    <= r_carry;
            done    <= 1'b1;
            r_state <= DONE;
          end else begin
            r_res   <= {w_bit, r_res[WIDTH-1:1]};
            r_sa    <= r_sa >> 1;
            r_sb    <= r_sb >> 1;
            r_carry <= w_cnext;
            r_cnt   <= r_cnt + CW'(1);
          end
        end
        DONE: begin
          done    <= 1'b0;
          gnt0    <= 1'b0;
          gnt1    <= 1'b0;
          busy    <= 1'b0;
          r_ptr   <= gnt0;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_serial_add_scheduler.sv
// ============================================================================
// tb_serial_add_scheduler : transaction-level model check of two DUT widths
// Revision 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_serial_add_scheduler;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  bit chk_en = 1'b0;

  // index 0: WIDTH=8 instance, index 1: WIDTH=4 instance
  logic       rq0 [2];
  logic       rq1 [2];
  logic [7:0] a0v [2];
  logic [7:0] b0v [2];
  logic [7:0] a1v [2];
  logic [7:0] b1v [2];

  logic       g0_8, g1_8, busy8, done8, cout8;
  logic [7:0] sum8;
  logic       g0_4, g1_4, busy4, done4, cout4;
  logic [3:0] sum4;

  serial_add_scheduler #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n),
    .req0(rq0[0]), .a0(a0v[0]), .b0(b0v[0]),
    .req1(rq1[0]), .a1(a1v[0]), .b1(b1v[0]),
    .gnt0(g0_8), .gnt1(g1_8), .busy(busy8), .done(done8),
    .sum(sum8), .cout(cout8)
  );

  serial_add_scheduler #(.WIDTH(4)) dut4 (
    .clk(clk), .rst_n(rst_n),
    .req0(rq0[1]), .a0(a0v[1][3:0]), .b0(b0v[1][3:0]),
    .req1(rq1[1]), .a1(a1v[1][3:0]), .b1(b1v[1][3:0]),
    .gnt0(g0_4), .gnt1(g1_4), .busy(busy4), .done(done4),
    .sum(sum4), .cout(cout4)
  );

  logic       d_g0 [2];
  logic       d_g1 [2];
  logic       d_busy [2];
  logic       d_done [2];
  logic       d_cout [2];
  logic [7:0] d_sum [2];
  assign d_g0[0] = g0_8;   assign d_g0[1] = g0_4;
  assign d_g1[0] = g1_8;   assign d_g1[1] = g1_4;
  assign d_busy[0] = busy8; assign d_busy[1] = busy4;
  assign d_done[0] = done8; assign d_done[1] = done4;
  assign d_cout[0] = cout8; assign d_cout[1] = cout4;
  assign d_sum[0] = sum8;  assign d_sum[1] = {4'h0, sum4};

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- transaction-level reference model ----------------
  logic       m_busy [2];
  logic       m_who [2];
  logic       m_ptr [2];
  logic       m_cout [2];
  int         m_age [2];
  logic [7:0] m_a [2];
  logic [7:0] m_b [2];
  logic [7:0] m_sum [2];

  function automatic int wof(input int i);
    return (i == 0) ? 8 : 4;
  endfunction

  function automatic logic [7:0] msk(input int i, input logic [7:0] v);
    return (i == 0) ? v : (v & 8'h0F);
  endfunction

  function automatic logic winner(input int i);
    return (rq0[i] && rq1[i]) ? m_ptr[i] : rq1[i];
  endfunction

  function automatic logic [8:0] total(input int i);
    return {1'b0, m_a[i]} + {1'b0, m_b[i]};
  endfunction

  function automatic logic [7:0] sumof(input int i);
    logic [8:0] t;
    t = total(i);
    return msk(i, t[7:0]);
  endfunction

  function automatic logic coutof(input int i);
    logic [8:0] t;
    t = total(i);
    return t[wof(i)];
  endfunction

  // A job owns the adder from its grant edge (age 0) through age W+1 (done).
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 2; i++) begin
        m_busy[i] <= 1'b0; m_who[i] <= 1'b0; m_ptr[i] <= 1'b0;
        m_cout[i] <= 1'b0; m_age[i] <= 0;    m_a[i] <= '0;
        m_b[i]    <= '0;   m_sum[i] <= '0;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (!m_busy[i]) begin
          if (rq0[i] || rq1[i]) begin
            m_busy[i] <= 1'b1;
            m_age[i]  <= 0;
            m_who[i]  <= winner(i);
            m_a[i]    <= msk(i, winner(i) ? a1v[i] : a0v[i]);
            m_b[i]    <= msk(i, winner(i) ? b1v[i] : b0v[i]);
          end
        end else begin
          m_age[i] <= m_age[i] + 1;
          if (m_age[i] == wof(i)) begin
            m_sum[i]  <= sumof(i);
            m_cout[i] <= coutof(i);
          end
          if (m_age[i] == wof(i) + 1) begin
            m_busy[i] <= 1'b0;
            m_ptr[i]  <= ~m_who[i];
          end
        end
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      for (int i = 0; i < 2; i++) begin
        chk($sformatf("i%0d_gnt0", i), d_g0[i], m_busy[i] && !m_who[i]);
        chk($sformatf("i%0d_gnt1", i), d_g1[i], m_busy[i] && m_who[i]);
        chk($sformatf("i%0d_busy", i), d_busy[i], m_busy[i]);
        chk($sformatf("i%0d_done", i), d_done[i], m_busy[i] && (m_age[i] == wof(i) + 1));
        chk($sformatf("i%0d_sum", i), d_sum[i], m_sum[i]);
        chk($sformatf("i%0d_cout", i), d_cout[i], m_cout[i]);
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic do_op(input int inst, input bit who, input logic [7:0] a, input logic [7:0] b,
                       input bit scramble, output int n, output int bc);
    if (who) begin a1v[inst] = a; b1v[inst] = b; rq1[inst] = 1'b1; end
    else     begin a0v[inst] = a; b0v[inst] = b; rq0[inst] = 1'b1; end
    step();
    chk($sformatf("op%0d_gnt", inst), who ? d_g1[inst] : d_g0[inst], 1);
    rq0[inst] = 1'b0;
    rq1[inst] = 1'b0;
    if (scramble) begin
      a0v[inst] = 8'hFF; b0v[inst] = 8'hFF; a1v[inst] = 8'hFF; b1v[inst] = 8'hFF;
    end
    bc = int'(d_busy[inst]);
    n = 0;
    do begin
      step();
      n++;
      bc += int'(d_busy[inst]);
    end while (!d_done[inst] && n < 40);
    chk($sformatf("op%0d_done_seen", inst), d_done[inst], 1);
    step();
    bc += int'(d_busy[inst]);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;
  endtask

  int         n, bc, ng, nd, last_dc, wt;
  int         order [4];
  int         gap [4];
  logic [7:0] sums [4];
  logic       prev_g;

  initial begin
    for (int i = 0; i < 2; i++) begin
      rq0[i] = 1'b0; rq1[i] = 1'b0;
      a0v[i] = '0; b0v[i] = '0; a1v[i] = '0; b1v[i] = '0;
    end
    #1 rst_n = 1'b0;
    chk_en = 1'b1;
    #1;
    chk("reset_busy", busy8, 0);
    chk("reset_gnt", {g0_8, g1_8}, 0);
    chk("reset_sum_cout", {cout8, sum8}, 0);
    step();
    rst_n = 1'b1;

    // first request after reset: 0x5A + 0x3C
    do_op(0, 1'b0, 8'h5A, 8'h3C, 1'b0, n, bc);
    chk("t1_done_latency", n, 9);
    chk("t1_sum", sum8, 8'h96);
    chk("t1_cout", cout8, 0);
    chk("t1_busy_cycles", bc, 10);

    do_op(0, 1'b1, 8'hFF, 8'h01, 1'b0, n, bc);
    chk("t2a_sum_cout", {cout8, sum8}, 9'h100);
    do_op(0, 1'b1, 8'h80, 8'h80, 1'b0, n, bc);
    chk("t2b_sum_cout", {cout8, sum8}, 9'h100);
    do_op(0, 1'b1, 8'h00, 8'h00, 1'b0, n, bc);
    chk("t2c_sum_cout", {cout8, sum8}, 9'h000);

    // operands overwritten and request dropped right after the grant
    do_op(0, 1'b0, 8'h11, 8'h22, 1'b1, n, bc);
    chk("t4_captured_sum", {cout8, sum8}, 9'h033);

    // both requesters held high from reset
    do_reset();
    a0v[0] = 8'h01; b0v[0] = 8'h02; a1v[0] = 8'h10; b1v[0] = 8'h20;
    rq0[0] = 1'b1; rq1[0] = 1'b1;
    ng = 0; nd = 0; last_dc = 0; prev_g = 1'b0;
    for (int c = 0; c < 60 && nd < 4; c++) begin
      step();
      if ((d_g0[0] | d_g1[0]) && !prev_g && ng < 4) begin
        order[ng] = int'(d_g1[0]);
        if (ng > 0) gap[ng-1] = c - last_dc;
        ng++;
      end
      if (d_done[0] && nd < 4) begin
        sums[nd] = d_sum[0];
        last_dc = c;
        nd++;
      end
      prev_g = d_g0[0] | d_g1[0];
    end
    rq0[0] = 1'b0; rq1[0] = 1'b0;
    chk("t3_done_count", nd, 4);
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("t3_order%0d", k), order[k], k % 2);
      chk($sformatf("t3_sum%0d", k), sums[k], (k % 2 == 0) ? 8'h03 : 8'h30);
    end
    for (int k = 0; k < 3; k++) chk($sformatf("t3_gap%0d", k), gap[k], 2);
    wt = 0;
    do begin step(); wt++; end while (d_busy[0] && wt < 20);
    chk("t3_idle_after", d_busy[0], 0);

    // randomized traffic on both widths
    for (int c = 0; c < 1500; c++) begin
      for (int i = 0; i < 2; i++) begin
        rq0[i] = 1'($urandom_range(0, 1));
        rq1[i] = 1'($urandom_range(0, 1));
        a0v[i] = 8'($urandom); b0v[i] = 8'($urandom);
        a1v[i] = 8'($urandom); b1v[i] = 8'($urandom);
      end
      step();
    end
    for (int i = 0; i < 2; i++) begin rq0[i] = 1'b0; rq1[i] = 1'b0; end
    for (int c = 0; c < 12; c++) step();

    // reset in the middle of RUN
    do_op(0, 1'b0, 8'hC3, 8'h5A, 1'b0, n, bc);
    rq0[0] = 1'b1; a0v[0] = 8'h77; b0v[0] = 8'h11;
    step();
    rq0[0] = 1'b0;
    for (int c = 0; c < 4; c++) step();
    rst_n = 1'b0;
    #1;
    chk("t5_abort_busy", busy8, 0);
    chk("t5_abort_gnt", {g0_8, g1_8}, 0);
    chk("t5_abort_done", done8, 0);
    chk("t5_abort_sum_cout", {cout8, sum8}, 0);
    step();
    step();
    rst_n = 1'b1;
    rq0[0] = 1'b1; rq1[0] = 1'b1;
    step();
    chk("t5_ptr_gnt0", g0_8, 1);
    chk("t5_ptr_gnt1", g1_8, 0);
    rq0[0] = 1'b0; rq1[0] = 1'b0;
    wt = 0;
    do begin step(); wt++; end while (d_busy[0] && wt < 20);
    chk("t5_idle_after", d_busy[0], 0);
    do_op(0, 1'b1, 8'h40, 8'h02, 1'b0, n, bc);
    chk("t5_req1_sum", {cout8, sum8}, 9'h042);

    // exhaustive 4-bit sweep through requester 0
    for (int a = 0; a < 16; a++) begin
      for (int b = 0; b < 16; b++) begin
        do_op(1, 1'b0, 8'(a), 8'(b), 1'b0, n, bc);
        chk($sformatf("sweep_%0d_%0d", a, b), {cout4, sum4}, a + b);
        chk($sformatf("sweep_busy_%0d_%0d", a, b), bc, 6);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

endmodule

`default_nettype wire
